// File: rtl/dmem_access_unit.sv
// Load/store unit between the MEM stage and a 16K x 32 synchronous SRAM.
// One request in flight; absorbs the SRAM read delay and returns a one-cycle response.
module dmem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        sram_CS,
   output logic        sram_OE,
   output logic [3:0]  sram_WEB,
   output logic [13:0] sram_A,
   output logic [31:0] sram_DI,
   input  logic [31:0] sram_DO
);

   typedef enum logic [1:0] {IDLE, RD_DATA, RESP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic        accept;
   logic        req_err;
   logic [3:0]  mask;
   logic [31:0] st_data;
   logic [31:0] lane;
   logic [31:0] load_val;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err_q;
   assign rsp_rdata = rdata_q;

   always_comb begin
      req_err = 1'b0;
      if (req_addr[31:16] != 16'd0) req_err = 1'b1;
      if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) req_err = 1'b1;
      if (req_write && (req_funct3 == 3'd4 || req_funct3 == 3'd5)) req_err = 1'b1;
      if ((req_funct3 == 3'd1 || req_funct3 == 3'd5) && req_addr[0]) req_err = 1'b1;
      if (req_funct3 == 3'd2 && req_addr[1:0] != 2'd0) req_err = 1'b1;
   end

   // Store data is replicated across lanes so the byte mask alone picks the target.
   always_comb begin
      mask    = 4'hF;
      st_data = req_wdata;
      case (req_funct3[1:0])
         2'd0: begin
            mask    = 4'b0001 << req_addr[1:0];
            st_data = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            mask    = 4'b0011 << req_addr[1:0];
            st_data = {2{req_wdata[15:0]}};
         end
         default: begin
            mask    = 4'hF;
            st_data = req_wdata;
         end
      endcase
   end

   always_comb begin
      lane     = sram_DO >> {off_q, 3'b000};
      load_val = lane;
      case (f3_q)
         3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
         3'd4:    load_val = {24'd0, lane[7:0]};
         3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
         3'd5:    load_val = {16'd0, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (req_err || req_write) ? RESP : RD_DATA;
         RD_DATA: state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SRAM pins rest at the idle value unless an access is launched this cycle.
   always_comb begin
      sram_CS  = 1'b0;
      sram_OE  = 1'b0;
      sram_WEB = 4'hF;
      sram_A   = 14'd0;
      sram_DI  = 32'd0;
      if (!rst) begin
         if (state == IDLE && accept && !req_err) begin
            sram_CS = 1'b1;
            sram_A  = req_addr[15:2];
            if (req_write) begin
               sram_WEB = ~mask;
               sram_DI  = st_data;
            end else begin
               sram_OE = 1'b1;
            end
         end else if (state == RD_DATA) begin
            sram_OE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            off_q <= req_addr[1:0];
            f3_q  <= req_funct3;
            err_q <= req_err;
            if (req_err || req_write) rdata_q <= 32'd0;
         end
         if (state == RD_DATA) rdata_q <= load_val;
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural 16K x 32 SRAM model.
module tb_dmem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        sram_CS;
   logic        sram_OE;
   logic [3:0]  sram_WEB;
   logic [13:0] sram_A;
   logic [31:0] sram_DI;
   logic [31:0] sram_DO;

   int tests_run;
   int tests_failed;

   logic [31:0] mem [0:16383];

   dmem_access_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .sram_CS(sram_CS), .sram_OE(sram_OE), .sram_WEB(sram_WEB),
      .sram_A(sram_A), .sram_DI(sram_DI), .sram_DO(sram_DO)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM model: byte-masked write, read data appears the cycle after sampling
   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
      sram_DO = 32'd0;
   end

   always @(posedge clk) begin
      if (sram_CS) begin
         for (int b = 0; b < 4; b++)
            if (!sram_WEB[b]) mem[sram_A][b*8 +: 8] <= sram_DI[b*8 +: 8];
         if (sram_OE) sram_DO <= mem[sram_A];
      end
   end

   // driver tasks
   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      #1;
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a);
      issue(1'b0, f3, a, 32'd0);
      idle_cycle();
      idle_cycle();
   endtask

   // scenarios
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      #1;
      tests_run++;
      if ({req_ready, sram_CS, sram_OE, sram_WEB, rsp_valid, rsp_err, rsp_rdata} !==
          {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%b cs=%b oe=%b web=%b v=%b e=%b d=%h want 0 0 0 1111 0 0 0",
                  req_ready, sram_CS, sram_OE, sram_WEB, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_store_word();
      issue(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF);
      tests_run++;
      if ({sram_CS, sram_OE, sram_WEB, sram_A, sram_DI} !== {1'b1, 1'b0, 4'b0000, 14'h041, 32'hDEAD_BEEF}) begin
         tests_failed++;
         $display("FAIL sw_sram: got cs=%b oe=%b web=%b a=%h di=%h want 1 0 0000 041 deadbeef",
                  sram_CS, sram_OE, sram_WEB, sram_A, sram_DI);
      end
      idle_cycle();
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_rdata, sram_CS} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL sw_rsp: got v=%b e=%b d=%h cs=%b want 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, sram_CS);
      end
      issue(1'b0, 3'd2, 32'h104, 32'd0);
      tests_run++;
      if ({sram_CS, sram_OE, sram_WEB, sram_A} !== {1'b1, 1'b1, 4'hF, 14'h041}) begin
         tests_failed++;
         $display("FAIL lw_sram: got cs=%b oe=%b web=%b a=%h want 1 1 1111 041", sram_CS, sram_OE, sram_WEB, sram_A);
      end
      idle_cycle();
      tests_run++;
      if ({rsp_valid, sram_CS, sram_OE, req_ready} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL lw_rd_data: got v=%b cs=%b oe=%b rdy=%b want 0 0 1 0", rsp_valid, sram_CS, sram_OE, req_ready);
      end
      idle_cycle();
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         tests_failed++;
         $display("FAIL lw_rsp: got v=%b e=%b d=%h want 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_byte();
      issue(1'b1, 3'd0, 32'h105, 32'h1234_56AA);
      tests_run++;
      if ({sram_CS, sram_WEB, sram_A, sram_DI} !== {1'b1, 4'b1101, 14'h041, 32'hAAAA_AAAA}) begin
         tests_failed++;
         $display("FAIL sb_sram: got cs=%b web=%b a=%h di=%h want 1 1101 041 aaaaaaaa", sram_CS, sram_WEB, sram_A, sram_DI);
      end
      idle_cycle();
      run_load(3'd0, 32'h105);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hFFFF_FFAA}) begin
         tests_failed++;
         $display("FAIL lb: got v=%b d=%h want 1 ffffffaa", rsp_valid, rsp_rdata);
      end
      run_load(3'd4, 32'h105);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_00AA}) begin
         tests_failed++;
         $display("FAIL lbu: got v=%b d=%h want 1 000000aa", rsp_valid, rsp_rdata);
      end
      run_load(3'd2, 32'h104);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEAD_AAEF}) begin
         tests_failed++;
         $display("FAIL lw_after_sb: got v=%b d=%h want 1 deadaaef", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_half();
      issue(1'b1, 3'd1, 32'h106, 32'h0000_8001);
      tests_run++;
      if ({sram_CS, sram_WEB, sram_DI} !== {1'b1, 4'b0011, 32'h8001_8001}) begin
         tests_failed++;
         $display("FAIL sh_sram: got cs=%b web=%b di=%h want 1 0011 80018001", sram_CS, sram_WEB, sram_DI);
      end
      idle_cycle();
      run_load(3'd1, 32'h106);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hFFFF_8001}) begin
         tests_failed++;
         $display("FAIL lh: got v=%b d=%h want 1 ffff8001", rsp_valid, rsp_rdata);
      end
      run_load(3'd5, 32'h106);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_8001}) begin
         tests_failed++;
         $display("FAIL lhu: got v=%b d=%h want 1 00008001", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_errors();
      logic        w_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3_t [5] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
      logic [31:0] a_t  [5] = '{32'h107, 32'h102, 32'h0001_0000, 32'h100, 32'h100};
      for (int i = 0; i < 5; i++) begin
         issue(w_t[i], f3_t[i], a_t[i], 32'hFFFF_FFFF);
         tests_run++;
         if ({req_ready, sram_CS, sram_OE, sram_WEB} !== {1'b1, 1'b0, 1'b0, 4'hF}) begin
            tests_failed++;
            $display("FAIL err%0d_sram: got rdy=%b cs=%b oe=%b web=%b want 1 0 0 1111",
                     i, req_ready, sram_CS, sram_OE, sram_WEB);
         end
         idle_cycle();
         tests_run++;
         if ({rsp_valid, rsp_err, rsp_rdata, sram_CS} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL err%0d_rsp: got v=%b e=%b d=%h cs=%b want 1 1 0 0",
                     i, rsp_valid, rsp_err, rsp_rdata, sram_CS);
         end
      end
   endtask

   task automatic test_back_to_back_load();
      logic e_acc;
      issue(1'b0, 3'd2, 32'h104, 32'd0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         e_acc = (i % 3 == 0);
         tests_run++;
         if ({req_ready, sram_CS, rsp_valid} !== {e_acc, e_acc, (i % 3 == 2)}) begin
            tests_failed++;
            $display("FAIL b2b_load_c%0d: got rdy=%b cs=%b v=%b want %b %b %b",
                     i, req_ready, sram_CS, rsp_valid, e_acc, e_acc, (i % 3 == 2));
         end
         if (i % 3 == 2) begin
            tests_run++;
            if (rsp_rdata !== 32'h8001_AAEF) begin
               tests_failed++;
               $display("FAIL b2b_load_data_c%0d: got %h want 8001aaef", i, rsp_rdata);
            end
         end
      end
      idle_cycle();
   endtask

   task automatic test_back_to_back_store();
      issue(1'b1, 3'd2, 32'h200, 32'h0BAD_F00D);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         tests_run++;
         if ({req_ready, sram_CS, rsp_valid} !== {(i % 2 == 0), (i % 2 == 0), (i % 2 == 1)}) begin
            tests_failed++;
            $display("FAIL b2b_store_c%0d: got rdy=%b cs=%b v=%b want %b %b %b",
                     i, req_ready, sram_CS, rsp_valid, (i % 2 == 0), (i % 2 == 0), (i % 2 == 1));
         end
      end
      idle_cycle();
      run_load(3'd2, 32'h200);
      tests_run++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
         tests_failed++;
         $display("FAIL b2b_store_readback: got v=%b d=%h want 1 0badf00d", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      issue(1'b0, 3'd2, 32'h104, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({sram_CS, sram_OE, sram_WEB, req_ready, rsp_valid} !== {1'b0, 1'b0, 4'hF, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_mid_read_during: got cs=%b oe=%b web=%b rdy=%b v=%b want 0 0 1111 0 0",
                  sram_CS, sram_OE, sram_WEB, req_ready, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL rst_mid_read_after: got rdy=%b v=%b e=%b d=%h want 1 0 0 0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
      idle_cycle();
      tests_run++;
      if ({rsp_valid, sram_CS} !== {1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_mid_read_no_rsp: got v=%b cs=%b want 0 0", rsp_valid, sram_CS);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_funct3   = 3'd0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      test_reset();
      test_store_word();
      test_byte();
      test_half();
      test_errors();
      test_back_to_back_load();
      test_back_to_back_store();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store access unit between the CPU MEM stage and the data-memory SRAM wrapper. Accepts one load/store request at a time and drives the SRAM macro's chip-select, output-enable, active-low byte write enables, word address and write data. Absorbs the SRAM's one-cycle read delay, aligns and sign/zero-extends load data, and returns a single-cycle response pulse. Misaligned, out-of-range and illegal-width accesses are rejected without touching the SRAM.

## Interface
- No parameters. Memory is fixed at 16K words × 32 bits (14-bit word address, byte address range 0x0000_0000–0x0000_FFFF).
- clk  in  1  single clock, rising edge; same clock as the SRAM wrapper's CK
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE and only while rst=0
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width: 0 B, 1 H, 2 W, 4 BU, 5 HU (BU/HU are loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low bits are used
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure
- rsp_rdata  out  32  aligned load result; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: access rejected
- sram_CS  out  1  SRAM chip select
- sram_OE  out  1  SRAM output enable
- sram_WEB  out  4  active-low byte write enables; WEB[0] covers bits 7:0
- sram_A  out  14  SRAM word address
- sram_DI  out  32  SRAM write data
- sram_DO  in  32  SRAM read data; valid the cycle after a read is sampled

## Operation
- **Accept:** a request is accepted when req_valid & req_ready.
- **States:** IDLE, RD_DATA, RESP.
- **Error check (combinational on the request):**
  - err when req_addr[31:16] != 0
  - or funct3 ∈ {3, 6, 7}
  - or req_write with funct3 ∈ {4, 5}
  - or H/HU with addr[0] = 1
  - or W with addr[1:0] != 0
- **Accepted with err:** no SRAM access. Go to RESP with rsp_err=1 and rsp_rdata=0.
- **Accepted store:**
  - Drive sram_CS=1, sram_A=addr[15:2], sram_OE=0.
  - B: DI = {4{wdata[7:0]}}, mask = 1<<addr[1:0].
  - H: DI = {2{wdata[15:0]}}, mask = 3<<addr[1:0].
  - W: DI = wdata, mask = 4'hF.
  - sram_WEB = ~mask.
  - Go to RESP with rsp_err=0 and rsp_rdata=0.
- **Accepted load:**
  - Drive sram_CS=1, sram_OE=1, sram_WEB=4'hF, sram_A=addr[15:2].
  - Latch addr[1:0] and funct3. Go to RD_DATA.
- **RD_DATA:**
  - sram_CS=0, sram_OE=1.
  - Select lane from sram_DO using the latched offset.
  - B: sign-extend byte. BU: zero-extend byte. H: sign-extend half. HU: zero-extend half. W: full word.
  - Register the result into rsp_rdata. Go to RESP.
- **RESP:** rsp_valid=1 for exactly one cycle, then IDLE.
- **SRAM idle value** (any cycle without an access): CS=0, OE=0, WEB=4'hF, A=0, DI=0.
- **SRAM control in IDLE** is combinational from the request, gated by the accept condition and by !rst.
- **Request hold:** req_valid held while not ready is simply not accepted. Request inputs are don't-care outside the accept cycle.

## Timing
- **Reset:**
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - SRAM outputs at idle value in the rst cycle, so no write can occur.
  - req_ready=0 while rst=1.
- **Read latency:** accept at T; SRAM samples at the end of T; DO is valid in T+1; response is in T+2. Next accept is possible at T+3.
- **Store and error latency:** accept at T; response in T+1. Next accept is possible at T+2.
- **Response:** rsp_rdata and rsp_err are valid only while rsp_valid=1. Outside RESP: rsp_valid=0 and rsp_err=0, and rsp_rdata holds its last value.
- **Reset mid-operation:** rst in RD_DATA or RESP abandons the access. No rsp_valid is produced for it; IDLE with req_ready=1 follows the first cycle after rst drops.
- **Back-to-back requests:** with req_valid held high, accepts occur every 3 cycles for loads and every 2 cycles for stores and errors.

## Test plan
- **Store word:** SW addr 0x104, wdata 0xDEADBEEF → at T: CS=1, A=0x041, WEB=4'b0000, DI=0xDEADBEEF; T+1: rsp_valid=1, rsp_err=0. Then LW 0x104 → rsp_rdata=0xDEADBEEF at T+2.
- **Byte access:** SB addr 0x105, wdata 0x123456AA → WEB=4'b1101, DI=0xAAAAAAAA. Then LB 0x105 → 0xFFFFFFAA; LBU 0x105 → 0x000000AA; LW 0x104 → 0xDEADAAEF.
- **Halfword access:** SH addr 0x106, wdata 0x8001 → WEB=4'b0011. Then LH 0x106 → 0xFFFF8001; LHU 0x106 → 0x00008001.
- **Errors:** LH 0x107, LW 0x102, SW 0x0001_0000, funct3=3, and store with funct3=4 → each gives rsp_valid and rsp_err=1 at T+1 with rsp_rdata=0. sram_CS stays 0 throughout.
- **Reset mid-read:** assert rst in the RD_DATA cycle of an LW → no rsp_valid; all outputs at reset values; req_ready=1 one cycle after rst deasserts.
- **Held request:** req_valid held high with a load stream → req_ready pulses once every 3 cycles; exactly one rsp_valid per accepted request; no sram_CS asserted outside accept cycles.
